// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared types and constants for the stochastic activation scheduler
package sc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WARM,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] SC_DEFAULT_SEED = 8'h01;

    // Feedback masks for a left-shifting Fibonacci LFSR (bit W-1 is the oldest bit)
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            12:      return 32'h0000_0829;
            16:      return 32'h0000_B400;
            default: return 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/sc_sng.sv
// rtl/sc_sng.sv - stochastic number generator: maximal-length LFSR plus unsigned comparator
module sc_sng
    import sc_pkg::*;
#(
    parameter int             W    = 8,
    parameter logic [W-1:0]   SEED = W'(SC_DEFAULT_SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_step,
    input  logic [W-1:0] i_value,
    output logic         o_bit
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= {r_lfsr[W-2:0], ^(r_lfsr & TAPS)};
        end
    end

    assign o_bit = (r_lfsr < i_value);

endmodule

// File: rtl/sc_act_sched.sv
// rtl/sc_act_sched.sv - round-robin scheduler sharing one SC activation unit among requesters
module sc_act_sched
    import sc_pkg::*;
#(
    parameter int           NREQ    = 4,
    parameter int           W       = 8,
    parameter int           LOG_LEN = 8,
    parameter int           WARMUP  = 8,
    parameter logic [W-1:0] SEED    = W'(SC_DEFAULT_SEED)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*W-1:0]        req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [LOG_LEN:0]         res_count,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     busy,
    output logic                     sc_x,
    output logic                     sc_clr,
    input  logic                     sc_y
);

    localparam int IW   = $clog2(NREQ);
    localparam int CNTW = LOG_LEN + 1;
    localparam int CW   = (($clog2(WARMUP) > LOG_LEN) ? $clog2(WARMUP) : LOG_LEN) + 1;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_id;
    logic [W-1:0]    r_op;
    logic [CW-1:0]   r_cyc;
    logic [CNTW-1:0] r_count;

    logic            w_found;
    logic [IW-1:0]   w_gnt;
    logic            w_grant;
    logic            w_stream;
    logic            w_bit;

    // Lowest offset from r_ptr wins, so scan offsets downward and let the last hit stick
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_gnt   = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_grant = reset_n && (r_state == S_IDLE) && w_found;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_op    <= '0;
            r_cyc   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_gnt;
                        r_op    <= req_data[w_gnt*W +: W];
                        r_ptr   <= IW'((int'(w_gnt) + 1) % NREQ);
                        r_state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_cyc   <= '0;
                    r_count <= '0;
                    r_state <= S_WARM;
                end
                S_WARM: begin
                    if (r_cyc == CW'(WARMUP - 1)) begin
                        r_cyc   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + CNTW'(sc_y);
                    if (r_cyc == CW'(2**LOG_LEN - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_stream = (r_state == S_WARM) || (r_state == S_RUN);

    sc_sng #(
        .W    (W),
        .SEED (SEED)
    ) u_sng (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_load  (r_state == S_CLEAR),
        .i_step  (w_stream),
        .i_value (r_op),
        .o_bit   (w_bit)
    );

    assign sc_x      = w_stream && w_bit;
    assign sc_clr    = (r_state == S_CLEAR);
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign res_count = r_count;
    assign res_id    = r_id;

endmodule

// File: tb/tb_sc_act_sched.sv
// tb/tb_sc_act_sched.sv - directed vector bench for sc_act_sched
module tb_sc_act_sched;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int LOG_LEN = 8;
    localparam int WARMUP  = 8;
    localparam int LAT     = 2 + WARMUP + 2**LOG_LEN;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*W-1:0]  req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [LOG_LEN:0]   res_count;
    logic [1:0]         res_id;
    logic               busy;
    logic               sc_x;
    logic               sc_clr;
    logic               sc_y;

    logic loop_mode = 1'b0;
    logic y_const   = 1'b1;
    assign sc_y = loop_mode ? sc_x : y_const;

    sc_act_sched #(
        .NREQ(NREQ), .W(W), .LOG_LEN(LOG_LEN), .WARMUP(WARMUP), .SEED(8'h01)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_id(res_id), .busy(busy), .sc_x(sc_x),
        .sc_clr(sc_clr), .sc_y(sc_y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int clr_total = 0;
    int clr_last  = -1;
    int x_total   = 0;
    always @(negedge clk) begin
        if (sc_clr) begin
            clr_total <= clr_total + 1;
            clr_last  <= cyc;
        end
        if (sc_x) x_total <= x_total + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // x^8+x^4+x^3+x^2+1 recurrence: new bit = b7 ^ b5 ^ b4 ^ b3, shifted in at bit 0
    function automatic int model_count(input logic [7:0] op);
        logic [7:0] l;
        logic       nb;
        int         c;
        l = 8'h01;
        c = 0;
        for (int i = 0; i < WARMUP + 2**LOG_LEN; i++) begin
            if (i >= WARMUP && l < op) c++;
            nb = l[7] ^ l[5] ^ l[4] ^ l[3];
            l  = {l[6:0], nb};
        end
        return c;
    endfunction

    task automatic wait_grant(output int gid, output int tg);
        gid = -1;
        tg  = 0;
        #1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready != '0) begin
                chk("grant_onehot", longint'($onehot(req_ready)), 1);
                for (int j = 0; j < NREQ; j++) if (req_ready[j]) gid = j;
                tg = cyc;
                return;
            end
            @(negedge clk);
        end
        chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_result(output int tr);
        tr = 0;
        for (int i = 0; i < 400; i++) begin
            if (res_valid) begin
                tr = cyc;
                return;
            end
            @(negedge clk);
        end
        chk("result_timeout", 0, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_job(input int rq, input logic [7:0] op, input logic lp, input int exp);
        int gid, tg, tr, c0, x0;
        loop_mode = lp;
        req_data[rq*W +: W] = op;
        c0 = clr_total;
        x0 = x_total;
        req_valid[rq] = 1'b1;
        wait_grant(gid, tg);
        chk("job_grant_id", gid, rq);
        @(posedge clk);
        #1;
        req_valid[rq] = 1'b0;
        wait_result(tr);
        chk("job_latency", tr - tg, LAT);
        chk("job_count", res_count, exp);
        chk("job_res_id", res_id, rq);
        handshake();
        @(negedge clk);
        chk("job_idle_after", busy, 0);
        chk("job_clr_pulses", clr_total - c0, 1);
        chk("job_clr_cycle", clr_last, tg + 1);
        if (op == 8'h00) chk("job_x_zero", x_total - x0, 0);
    endtask

    typedef struct {
        int         rq;
        logic [7:0] op;
        logic       lp;
        int         exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        int g, t, tr, snap_cnt, stable;
        logic [18:0] outs;

        vt[0] = '{rq: 0, op: 8'h80, lp: 1'b0, exp: 256};
        vt[1] = '{rq: 1, op: 8'h00, lp: 1'b1, exp: 0};
        vt[2] = '{rq: 2, op: 8'h80, lp: 1'b1, exp: -1};
        vt[3] = '{rq: 3, op: 8'hFF, lp: 1'b1, exp: -1};
        vt[4] = '{rq: 0, op: 8'h01, lp: 1'b1, exp: 0};
        vt[5] = '{rq: 1, op: 8'h00, lp: 1'b0, exp: 256};

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        outs = {req_ready, res_valid, res_count, res_id, busy, sc_x, sc_clr};
        chk("reset_outputs", outs, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_job(vt[i].rq, vt[i].op, vt[i].lp,
                    (vt[i].exp < 0) ? model_count(vt[i].op) : vt[i].exp);
        end

        // Fairness 0,2,0 plus DONE back-pressure, starting from ptr=0
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        loop_mode = 1'b1;
        req_data[0*W +: W] = 8'h80;
        req_data[2*W +: W] = 8'h40;
        req_valid = 4'b0101;
        wait_grant(g, t);
        chk("rr_first", g, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_result(tr);
        chk("rr_first_count", res_count, model_count(8'h80));
        handshake();
        wait_grant(g, t);
        chk("rr_second", g, 2);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1;
        wait_result(tr);
        chk("rr_second_count", res_count, model_count(8'h40));
        chk("rr_second_id", res_id, 2);
        snap_cnt = int'(res_count);
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid || int'(res_count) != snap_cnt || res_id != 2'd2 || req_ready != '0)
                stable = 0;
        end
        chk("done_stable", stable, 1);
        res_ready = 1'b1;
        #1;
        chk("no_ready_in_handshake", req_ready, 0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("ready_after_handshake", req_ready, 4'b0001);
        wait_grant(g, t);
        chk("rr_third", g, 0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        wait_result(tr);
        chk("rr_third_count", res_count, model_count(8'h80));
        handshake();

        // Reset mid-RUN abandons the job; pointer returns to 0
        req_data[1*W +: W] = 8'h80;
        req_valid = 4'b0010;
        wait_grant(g, t);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (100) @(negedge clk);
        chk("busy_mid_run", busy, 1);
        reset_n = 1'b0;
        #1;
        outs = {req_ready, res_valid, res_count, res_id, busy, sc_x, sc_clr};
        chk("midrun_reset_outputs", outs, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 8'h80;
        req_valid = 4'b1111;
        wait_grant(g, t);
        chk("ptr_after_reset", g, 0);
        @(posedge clk); #1;
        req_valid = '0;
        wait_result(tr);
        chk("post_reset_latency", tr - t, LAT);
        chk("post_reset_count", res_count, model_count(8'h80));
        chk("post_reset_id", res_id, 0);
        handshake();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
